nn_serial_evaluator: RTL and testbench
======================================

Name: nn_serial_evaluator

Overview:
Time-multiplexed evaluator for the two-layer threshold network: one shared multiply/accumulate unit evaluates every hidden and output neuron in turn.
- Weights are streamed from a synchronous weight memory (genome RAM) instead of the full flattened weight bus, so a population of genomes can be scored without instantiating one neuron per node.
- Sits between the neuroevolution top level, which supplies the input vector and start, and the genome weight RAM.

Parameters:
data_width, `NN_DATA_WIDTH, word width; unsigned fixed point with data_width/2 fraction bits
input_size, `NN_INPUT_SIZE, network inputs I
hidden_size, `NN_HIDDEN_SIZE, hidden neurons H
output_size, `NN_OUTPUT_SIZE, output neurons O
addr_width, 16, weight memory address width; must hold N-1, where N = H*(I+1) + O*(H+1)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request an evaluation; accepted only when busy=0
input_data  in  data_width*I  input vector, word k at [data_width*k +: data_width]; sampled on the accepting edge only
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse; output_data is valid from this cycle on
weight_rd  out  1  weight memory read strobe
weight_addr  out  addr_width  weight word index
weight_data  in  data_width  read data, valid exactly 1 cycle after weight_rd
output_data  out  data_width*O  result vector, word j = output neuron j

Behaviour:
- Reset (async, resetn=0): all outputs are 0, state=IDLE, latched inputs, hidden results and accumulator are 0. Reset mid-evaluation aborts with no done pulse.
- Weight layout:
  - Hidden neuron j, index j*(I+1)+k: weight for input k (k<I); index j*(I+1)+I is its threshold.
  - Output neuron j, index H*(I+1)+j*(H+1)+k: same layout over the hidden results.
- Arithmetic, bit-exact:
  - product = ({0,x} * {0,w}) >> (data_width/2), truncated to data_width bits.
  - Accumulation wraps modulo 2^data_width.
  - Neuron result = (acc >= threshold) ? 1<<(data_width/2) : 0, unsigned compare.
- States: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - On start=1: latch input_data, clear output_data and hidden results, enter RUN.
  - busy=1 from the next cycle.
- RUN:
  - weight_rd=1 for exactly N consecutive cycles, weight_addr = 0,1,...,N-1.
  - After the cycle issuing addr N-1, go to DRAIN.
- Data-phase pipeline, 1 cycle behind address:
  - First weight of a neuron: acc = product, with no accumulation into the previous acc.
  - Other weights: acc = acc + product.
  - Threshold word: compare, then register the result into hidden result j or output_data word j. acc is don't-care afterwards.
  - Output-layer multiplicand is the registered hidden result. No hazard exists: hidden neuron H-1's result is written before any output weight k=H-1 arrives.
- DRAIN:
  - One cycle consuming the final threshold word.
  - The next cycle is IDLE with done=1 and busy=0.
  - Start-to-done latency is exactly N+2 cycles.
- output_data holds until the next accepted start, which clears it to 0.
- start while busy=1 is ignored; no queueing.
- start asserted in the same cycle done=1 is accepted, because the block is already IDLE.
- The weight_data value is ignored in cycles not following a weight_rd.

Decomposition:
- Shared constants header, alongside the existing NN_* macros:
  - State encoding localparams.
  - Total-weight-count macro N(I,H,O).
  - Neuron weight stride macros (I+1 and H+1).
- Sub-module nn_mac_unit: product, accumulate-or-load, and threshold compare, purely combinational plus the acc register. Reused by any future parallel-lane variant.
- Sequencing counters live in the top: address, neuron index, weight-within-neuron index, layer flag.

Test Plan:
- W=8, I=2, H=2, O=1 (N=9), inputs [16,16], all weights 16, all thresholds 32 -> each hidden=16; output_data=16; done exactly 11 cycles after start.
- Same config, output threshold 33 -> output_data=0; hidden thresholds 48 with output threshold 0 -> output_data=16 (0>=0).
- Wrap: input0=255, weight0=255, weight1=0, hidden0 threshold 224 -> product 224, hidden0=16; threshold 225 -> hidden0=0.
- Address trace: weight_addr 0..8 on consecutive cycles with weight_rd high 9 cycles; start pulsed mid-run has no effect on the trace or result.
- resetn low at cycle 5 of a run -> busy, done, weight_rd, output_data=0 immediately; no done pulse; a fresh start then completes normally.
- Back-to-back: start held high -> second evaluation accepted in the done cycle; output_data reads 0 during the run, then shows the new result on its done.

Source files
------------

// File: rtl/nn_serial_evaluator_pkg.sv
// Shared constants for the serial two-layer threshold network evaluator:
// default network shape, weight-count/stride macros and FSM state encoding.
`ifndef NN_DATA_WIDTH
`define NN_DATA_WIDTH 8
`endif
`ifndef NN_INPUT_SIZE
`define NN_INPUT_SIZE 2
`endif
`ifndef NN_HIDDEN_SIZE
`define NN_HIDDEN_SIZE 2
`endif
`ifndef NN_OUTPUT_SIZE
`define NN_OUTPUT_SIZE 1
`endif
`ifndef NN_WEIGHT_COUNT
`define NN_WEIGHT_COUNT(I, H, O) ((H) * ((I) + 1) + (O) * ((H) + 1))
`endif
`ifndef NN_HIDDEN_STRIDE
`define NN_HIDDEN_STRIDE(I) ((I) + 1)
`endif
`ifndef NN_OUTPUT_STRIDE
`define NN_OUTPUT_STRIDE(H) ((H) + 1)
`endif

package nn_serial_evaluator_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_DRAIN = ST_DRAIN_ENC
    } nn_state_e;

endpackage

// File: rtl/nn_serial_evaluator_mac_unit.sv
// Shared multiply/accumulate lane: fixed-point product, load-or-accumulate
// register and unsigned threshold compare against the current weight word.
module nn_mac_unit #(
    parameter int data_width = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  acc_en_i,
    input  logic                  load_i,
    input  logic [data_width-1:0] x_i,
    input  logic [data_width-1:0] w_i,
    output logic                  ge_o
);
    localparam int W = data_width;

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] prod;

    // Unsigned Q(W/2) multiply, rescaled and truncated back to one word.
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) >> (W / 2));
    endfunction

    always_comb begin
        prod  = fx_mul(x_i, w_i);
        acc_d = load_i ? prod : acc_q + prod;
    end

    assign ge_o = (acc_q >= w_i);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/nn_serial_evaluator.sv
// Time-multiplexed two-layer threshold network: one MAC lane walks every hidden
// and output neuron, streaming weights from a synchronous genome RAM.
module nn_serial_evaluator
    import nn_serial_evaluator_pkg::*;
#(
    parameter int data_width  = `NN_DATA_WIDTH,
    parameter int input_size  = `NN_INPUT_SIZE,
    parameter int hidden_size = `NN_HIDDEN_SIZE,
    parameter int output_size = `NN_OUTPUT_SIZE,
    parameter int addr_width  = 16
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              start,
    input  logic [data_width*input_size-1:0]  input_data,
    output logic                              busy,
    output logic                              done,
    output logic                              weight_rd,
    output logic [addr_width-1:0]             weight_addr,
    input  logic [data_width-1:0]             weight_data,
    output logic [data_width*output_size-1:0] output_data
);
    localparam int W    = data_width;
    localparam int I    = input_size;
    localparam int H    = hidden_size;
    localparam int O    = output_size;
    localparam int N    = `NN_WEIGHT_COUNT(I, H, O);
    localparam int MAXK = (I > H) ? I : H;
    localparam int KW   = $clog2(MAXK + 1);
    localparam int MAXN = (H > O) ? H : O;
    localparam int NW   = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [W-1:0] FX_ONE = {{(W-1){1'b0}}, 1'b1} << (W / 2);

    nn_state_e             state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [KW-1:0]         k_q, k_d;
    logic [NW-1:0]         nrn_q, nrn_d;
    logic                  layer_q, layer_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  last_k;
    logic                  last_nrn;

    logic                  vld_p1;
    logic [KW-1:0]         k_p1;
    logic [NW-1:0]         nrn_p1;
    logic                  layer_p1;
    logic                  first_p1;
    logic                  thr_p1;

    logic [W-1:0]          in_q  [I];
    logic [W-1:0]          hid_q [H];
    logic [W-1:0]          out_q [O];
    logic [W-1:0]          x_sel;
    logic                  ge;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        k_d      = k_q;
        nrn_d    = nrn_q;
        layer_d  = layer_q;
        accept   = 1'b0;
        last_k   = layer_q ? (k_q == KW'(`NN_OUTPUT_STRIDE(H) - 1))
                           : (k_q == KW'(`NN_HIDDEN_STRIDE(I) - 1));
        last_nrn = layer_q ? (nrn_q == NW'(O - 1)) : (nrn_q == NW'(H - 1));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                    addr_d  = '0;
                    k_d     = '0;
                    nrn_d   = '0;
                    layer_d = 1'b0;
                end
            end
            ST_RUN: begin
                addr_d = addr_q + addr_width'(1);
                if (last_k) begin
                    k_d = '0;
                    if (last_nrn) begin
                        nrn_d   = '0;
                        layer_d = 1'b1;
                    end else begin
                        nrn_d = nrn_q + NW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
                if (addr_q == addr_width'(N - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_DRAIN);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            k_q     <= '0;
            nrn_q   <= '0;
            layer_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            nrn_q   <= nrn_d;
            layer_q <= layer_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign weight_rd   = (state_q == ST_RUN);
    assign weight_addr = addr_q;

    // Data phase: the RAM answers one cycle after the address, so the
    // sequencing context is delayed by one stage to meet weight_data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1   <= 1'b0;
            k_p1     <= '0;
            nrn_p1   <= '0;
            layer_p1 <= 1'b0;
            first_p1 <= 1'b0;
            thr_p1   <= 1'b0;
        end else begin
            vld_p1   <= weight_rd;
            k_p1     <= k_q;
            nrn_p1   <= nrn_q;
            layer_p1 <= layer_q;
            first_p1 <= (k_q == '0);
            thr_p1   <= last_k;
        end
    end

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < I; i++) begin
            if (!layer_p1 && k_p1 == KW'(i)) x_sel = in_q[i];
        end
        for (int j = 0; j < H; j++) begin
            if (layer_p1 && k_p1 == KW'(j)) x_sel = hid_q[j];
        end
    end

    nn_mac_unit #(
        .data_width(W)
    ) u_mac (
        .clock   (clock),
        .resetn  (resetn),
        .acc_en_i(vld_p1 && !thr_p1),
        .load_i  (first_p1),
        .x_i     (x_sel),
        .w_i     (weight_data),
        .ge_o    (ge)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < I; i++) in_q[i] <= '0;
            for (int j = 0; j < H; j++) hid_q[j] <= '0;
            for (int j = 0; j < O; j++) out_q[j] <= '0;
        end else if (accept) begin
            for (int i = 0; i < I; i++) in_q[i] <= input_data[W*i +: W];
            for (int j = 0; j < H; j++) hid_q[j] <= '0;
            for (int j = 0; j < O; j++) out_q[j] <= '0;
        end else if (vld_p1 && thr_p1) begin
            for (int j = 0; j < H; j++) begin
                if (!layer_p1 && nrn_p1 == NW'(j)) hid_q[j] <= ge ? FX_ONE : '0;
            end
            for (int j = 0; j < O; j++) begin
                if (layer_p1 && nrn_p1 == NW'(j)) out_q[j] <= ge ? FX_ONE : '0;
            end
        end
    end

    for (genvar j = 0; j < O; j++) begin : g_out
        assign output_data[W*j +: W] = out_q[j];
    end

endmodule

// File: tb/tb_nn_serial_evaluator.sv
// Scoreboard bench for nn_serial_evaluator (W=8, I=2, H=2, O=1) with a
// behavioural network model and a synchronous genome RAM model.
module tb_nn_serial_evaluator;
    localparam int W = 8;
    localparam int I = 2;
    localparam int H = 2;
    localparam int O = 1;
    localparam int N = H * (I + 1) + O * (H + 1);

    typedef struct {
        logic [W-1:0] out;
        int           cyc;
    } exp_t;

    logic           clock = 1'b0;
    logic           resetn;
    logic           start;
    logic [W*I-1:0] input_data;
    logic           busy;
    logic           done;
    logic           weight_rd;
    logic [15:0]    weight_addr;
    logic [W-1:0]   weight_data = '0;
    logic [W*O-1:0] output_data;

    logic [W-1:0]   mem [N];
    exp_t           sb_q [$];
    int             cyc = 0;
    int             n_cmp = 0;
    int             n_fail = 0;
    int             addr_exp = 0;
    logic [W-1:0]   last_out = '0;

    nn_serial_evaluator #(
        .data_width (W),
        .input_size (I),
        .hidden_size(H),
        .output_size(O),
        .addr_width (16)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .input_data (input_data),
        .busy       (busy),
        .done       (done),
        .weight_rd  (weight_rd),
        .weight_addr(weight_addr),
        .weight_data(weight_data),
        .output_data(output_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous genome RAM; garbage on the bus when not read.
    always @(posedge clock) begin
        if (weight_rd) weight_data <= mem[weight_addr];
        else           weight_data <= W'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Network evaluated directly from the weight layout with plain integers.
    function automatic logic [W-1:0] model(input logic [W-1:0] x0, input logic [W-1:0] x1);
        int x [I];
        int hid [H];
        int acc;
        int base;
        x[0] = x0;
        x[1] = x1;
        for (int j = 0; j < H; j++) begin
            acc = 0;
            for (int k = 0; k < I; k++)
                acc = (acc + ((x[k] * int'(mem[j*(I+1)+k])) >> (W/2))) % (1 << W);
            hid[j] = (acc >= int'(mem[j*(I+1)+I])) ? (1 << (W/2)) : 0;
        end
        base = H * (I + 1);
        acc = 0;
        for (int k = 0; k < H; k++)
            acc = (acc + ((hid[k] * int'(mem[base+k])) >> (W/2))) % (1 << W);
        return (acc >= int'(mem[base+H])) ? W'(1 << (W/2)) : '0;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            addr_exp = 0;
            last_out = '0;
        end else begin
            if (weight_rd) begin
                chk("weight_addr", 32'(weight_addr), 32'(addr_exp));
                addr_exp++;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending evaluation (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", 32'(output_data), 32'(e.out));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    chk("rd_count", 32'(addr_exp), 32'(N));
                    chk("busy_at_done", 32'(busy), 32'(0));
                    last_out = e.out;
                end
                addr_exp = 0;
            end else if (busy) begin
                chk("out_cleared", 32'(output_data), 32'(0));
            end else begin
                chk("out_hold", 32'(output_data), 32'(last_out));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clock);
            #1;
            t++;
        end while (sb_q.size() != 0 && t < 40);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected %0d pending", t, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_eval(input logic [W-1:0] v0, input logic [W-1:0] v1, input int pulse_at);
        @(negedge clock);
        input_data = {v1, v0};
        start = 1'b1;
        sb_q.push_back('{model(v0, v1), cyc + N + 2});
        @(negedge clock);
        start = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at) @(negedge clock);
            input_data = {W*I{1'b1}};
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic set_uniform(input logic [W-1:0] w, input logic [W-1:0] hthr, input logic [W-1:0] othr);
        for (int j = 0; j < H; j++) begin
            for (int k = 0; k < I; k++) mem[j*(I+1)+k] = w;
            mem[j*(I+1)+I] = hthr;
        end
        for (int k = 0; k < H; k++) mem[H*(I+1)+k] = w;
        mem[N-1] = othr;
    endtask

    initial begin
        int c;
        resetn = 1'b0;
        start = 1'b0;
        input_data = '0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rd", 32'(weight_rd), 32'(0));
        chk("rst_addr", 32'(weight_addr), 32'(0));
        chk("rst_out", 32'(output_data), 32'(0));
        @(negedge clock);
        #2 resetn = 1'b1;

        set_uniform(8'd16, 8'd32, 8'd32);
        run_eval(8'd16, 8'd16, 0);
        set_uniform(8'd16, 8'd32, 8'd33);
        run_eval(8'd16, 8'd16, 3);
        set_uniform(8'd16, 8'd48, 8'd0);
        run_eval(8'd16, 8'd16, 0);

        mem[0] = 8'd255; mem[1] = 8'd0;  mem[2] = 8'd224;
        mem[3] = 8'd0;   mem[4] = 8'd0;  mem[5] = 8'd255;
        mem[6] = 8'd16;  mem[7] = 8'd0;  mem[8] = 8'd16;
        run_eval(8'd255, 8'd77, 0);
        mem[2] = 8'd225;
        run_eval(8'd255, 8'd77, 5);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) mem[i] = W'($urandom);
            run_eval(W'($urandom), W'($urandom), ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6)) : 0);
        end

        // Abort a run with reset after leaving a non-zero result behind.
        set_uniform(8'd16, 8'd32, 8'd32);
        run_eval(8'd16, 8'd16, 0);
        @(negedge clock);
        input_data = {8'd16, 8'd16};
        start = 1'b1;
        sb_q.push_back('{model(8'd16, 8'd16), cyc + N + 2});
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_rd", 32'(weight_rd), 32'(0));
        chk("abort_out", 32'(output_data), 32'(0));
        sb_q.delete();
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        repeat (N + 4) @(negedge clock);
        set_uniform(8'd16, 8'd32, 8'd32);
        run_eval(8'd16, 8'd16, 0);

        // Start held high: second run accepted in the done cycle of the first;
        // input_data changes mid-run must not affect the first result.
        mem[0] = 8'd32; mem[1] = 8'd0;  mem[2] = 8'd40;
        mem[3] = 8'd0;  mem[4] = 8'd16; mem[5] = 8'd16;
        mem[6] = 8'd16; mem[7] = 8'd16; mem[8] = 8'd32;
        @(negedge clock);
        input_data = {8'd16, 8'd32};
        start = 1'b1;
        c = cyc;
        sb_q.push_back('{model(8'd32, 8'd16), cyc + N + 2});
        repeat (3) @(negedge clock);
        input_data = {8'd16, 8'd8};
        while (cyc < c + N + 2) @(negedge clock);
        sb_q.push_back('{model(8'd8, 8'd16), cyc + N + 2});
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
